// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit between execute and writeback.
// It takes one decoded memory op and issues one word-aligned bus access.
// For stores it builds the byte-lane mask and replicated write data.
// For loads it extracts the addressed byte/half and sign/zero-extends it.
// Illegal memops and misaligned addresses respond with an error and make no bus access.
// Optional: define LSU_TIMEOUT_EN to abort a bus access that waits TIMEOUT_CYCLES
// cycles without mem_ack_i.
module riscv_lsu #(
  parameter int XLEN = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_memop_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_wmask_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int NUM_LANES  = XLEN / 8;
  localparam int LANE_IDX_W = $clog2(NUM_LANES);

`ifdef LSU_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  // Load-side control captured at the handshake and used when the ack returns.
  typedef struct packed {
    logic [LANE_IDX_W-1:0] off;
    logic [1:0]            size;  // 00 byte, 01 half, 10 word
    logic                  uns;   // zero-extend
  } ld_ctl_t;

  state_e          state_q;
  ld_ctl_t         ld_q;
  logic            ready_q, rsp_valid_q, rsp_err_q;
  logic            mem_req_q, mem_we_q;
  logic [XLEN-1:0] rsp_rdata_q, mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_wmask_q;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]      tmo_q;
`endif

  // Request decode. Memop bit 2 only selects extension, so stores treat 100/101 as B/H.
  logic [1:0] req_size;
  logic       req_illegal, req_misal, req_bad;
  assign req_size    = req_memop_i[1:0];
  assign req_illegal = (req_size == 2'b11) || (req_memop_i[2] && req_size[1]);
  assign req_misal   = ((req_size == 2'b01) && req_addr_i[0]) ||
                       ((req_size == 2'b10) && (req_addr_i[LANE_IDX_W-1:0] != '0));
  assign req_bad     = req_illegal || req_misal;

  // Per-lane store data replication and byte-enable generation.
  logic [NUM_LANES-1:0][7:0] wd_lanes, st_lanes;
  logic [NUM_LANES-1:0]      st_mask;
  logic [XLEN-1:0]           st_wdata;
  assign wd_lanes = req_wdata_i;
  assign st_wdata = st_lanes;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign st_lanes[i] = (req_size == 2'b00) ? wd_lanes[0] :
                         (req_size == 2'b01) ? wd_lanes[i % 2] : wd_lanes[i];
    assign st_mask[i]  = (req_size == 2'b00) ? (req_addr_i[LANE_IDX_W-1:0] == LANE_IDX_W'(i)) :
                         (req_size == 2'b01) ? (req_addr_i[1] == 1'(i / 2)) : 1'b1;
  end

  // Load extraction from the returning word.
  logic [NUM_LANES-1:0][7:0] rd_lanes;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [XLEN-1:0]           ld_data;
  assign rd_lanes = mem_rdata_i;
  assign ld_byte  = rd_lanes[ld_q.off];
  assign ld_half  = {rd_lanes[{ld_q.off[1], 1'b1}], rd_lanes[{ld_q.off[1], 1'b0}]};

  // Sign or zero extension selected by the captured memop.
  always_comb begin
    case (ld_q.size)
      2'b00:   ld_data = {{(XLEN-8){~ld_q.uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{(XLEN-16){~ld_q.uns & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Control FSM with registered outputs: IDLE -> BUS -> RESP, or IDLE -> RESP on error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      ld_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            ready_q   <= 1'b0;
            ld_q.off  <= req_addr_i[LANE_IDX_W-1:0];
            ld_q.size <= req_size;
            ld_q.uns  <= req_memop_i[2];
            if (req_bad) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q     <= S_BUS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we_i;
              mem_addr_q  <= {req_addr_i[XLEN-1:LANE_IDX_W], {LANE_IDX_W{1'b0}}};
              mem_wdata_q <= req_we_i ? st_wdata : '0;
              mem_wmask_q <= req_we_i ? st_mask : 4'b0000;
`ifdef LSU_TIMEOUT_EN
              tmo_q       <= '0;
`endif
            end
          end
        end
        S_BUS: begin
          if (mem_ack_i) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= mem_we_q ? '0 : ld_data;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'b0000;
          end
`ifdef LSU_TIMEOUT_EN
          // An ack in the limit cycle takes priority over the abort.
          else if (tmo_q == TMO_LIM - 8'd1) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'b0000;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wmask_o = mem_wmask_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: scoreboard of expected responses, one task per scenario.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_memop = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err, req_ready;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  riscv_lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) u_dut (
`else
  riscv_lsu #(.XLEN(32)) u_dut (
`endif
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_memop_i(req_memop), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * a[1:0]);
    case (op)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [35:0] model_store(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] wd);
    case (op[1:0])
      2'b00:   return {{4{wd[7:0]}}, 4'b0001 << a[1:0]};
      2'b01:   return {{2{wd[15:0]}}, (a[1] ? 4'b1100 : 4'b0011)};
      default: return {wd, 4'b1111};
    endcase
  endfunction

  // One-cycle request; returns 1ns into the cycle after the handshake edge.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_memop = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic er);
    exp_t e;
    e.rdata = rd; e.err = er;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask}
        !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0})
      begin errors++; $display("FAIL reset_state: got ready=%b rsp_v=%b mem_req=%b addr=%h wmask=%h want ready=1, rest 0",
                               req_ready, rsp_valid, mem_req, mem_addr, mem_wmask); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, mem_req} !== 3'b100)
      begin errors++; $display("FAIL reset_release: got ready/rsp_v/mem_req=%b want 100", {req_ready, rsp_valid, mem_req}); end
  endtask

  task automatic test_load();
    logic [2:0]  t_op [7] = '{3'b000, 3'b101, 3'b001, 3'b100, 3'b000, 3'b001, 3'b010};
    logic [31:0] t_ad [7] = '{32'h1003, 32'h2002, 32'h2002, 32'h1001, 32'h1002, 32'h2000, 32'h4004};
    logic [31:0] t_w  [7] = '{32'h80FF_1234, 32'h8001_7FFF, 32'h8001_7FFF, 32'h80FF_1234,
                              32'h80FF_1234, 32'h8001_7FFF, 32'hDEAD_BEEF};
    logic [31:0] t_ex [7] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_0012,
                              32'hFFFF_FFFF, 32'h0000_7FFF, 32'hDEAD_BEEF};
    int          t_wt [7] = '{0, 1, 2, 0, 3, 0, 1};
    logic [2:0]  ops5 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  op;
    logic [31:0] ad, w, ex;
    int          wt;
    exp_t        e;
    for (int k = 0; k < 13; k++) begin
      if (k < 7) begin
        op = t_op[k]; ad = t_ad[k]; w = t_w[k]; ex = t_ex[k]; wt = t_wt[k];
      end else begin
        op = ops5[$urandom_range(4)]; ad = $urandom; w = $urandom; wt = $urandom_range(2);
        if (op[1:0] == 2'b01) ad[0] = 1'b0;
        if (op[1:0] == 2'b10) ad[1:0] = 2'b00;
        ex = model_load(op, ad, w);
      end
      push_exp(ex, 1'b0);
      issue(1'b0, op, ad, 32'hFFFF_FFFF);
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wmask, req_ready, rsp_valid}
          !== {1'b1, 1'b0, ad & 32'hFFFF_FFFC, 4'h0, 1'b0, 1'b0})
        begin errors++; $display("FAIL load_bus[%0d]: got req=%b we=%b addr=%h wmask=%h ready=%b want req=1 we=0 addr=%h wmask=0 ready=0",
                                 k, mem_req, mem_we, mem_addr, mem_wmask, req_ready, ad & 32'hFFFF_FFFC); end
      for (int j = 0; j < wt; j++) begin
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || rsp_valid !== 1'b0)
          begin errors++; $display("FAIL load_wait[%0d]: got mem_req=%b rsp_v=%b want 1/0", k, mem_req, rsp_valid); end
      end
      mem_ack = 1'b1; mem_rdata = w;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1)
        begin errors++; $display("FAIL load_rsp_valid[%0d]: got %b want 1", k, rsp_valid); end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err})
          begin errors++; $display("FAIL load_data[%0d] op=%b addr=%h: got rdata=%h err=%b want rdata=%h err=%b",
                                   k, op, ad, rsp_rdata, rsp_err, e.rdata, e.err); end
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, mem_req} !== 3'b010)
        begin errors++; $display("FAIL load_done[%0d]: got rsp_v/ready/mem_req=%b want 010", k, {rsp_valid, req_ready, mem_req}); end
    end
  endtask

  task automatic test_store();
    logic [2:0]  t_op [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] t_ad [5] = '{32'h3001, 32'h3002, 32'h3008, 32'h3003, 32'h3000};
    logic [31:0] t_wd [5] = '{32'h1234_56AB, 32'h0000_CAFE, 32'h1122_3344, 32'h0000_005A, 32'h0000_BEEF};
    logic [31:0] t_ew [5] = '{32'hABAB_ABAB, 32'hCAFE_CAFE, 32'h1122_3344, 32'h5A5A_5A5A, 32'hBEEF_BEEF};
    logic [3:0]  t_em [5] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000, 4'b0011};
    logic [2:0]  op;
    logic [31:0] ad, wd, ew;
    logic [3:0]  em;
    exp_t        e;
    for (int k = 0; k < 9; k++) begin
      if (k < 5) begin
        op = t_op[k]; ad = t_ad[k]; wd = t_wd[k]; ew = t_ew[k]; em = t_em[k];
      end else begin
        op = 3'($urandom_range(2)); ad = $urandom; wd = $urandom;
        if (op[1:0] == 2'b01) ad[0] = 1'b0;
        if (op[1:0] == 2'b10) ad[1:0] = 2'b00;
        {ew, em} = model_store(op, ad, wd);
      end
      push_exp(32'h0, 1'b0);
      issue(1'b1, op, ad, wd);
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 1'b1, ad & 32'hFFFF_FFFC, ew, em})
          begin errors++; $display("FAIL store_bus[%0d.%0d]: got req=%b we=%b addr=%h wdata=%h wmask=%b want 1 1 %h %h %b",
                                   k, j, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ad & 32'hFFFF_FFFC, ew, em); end
      end
      mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1)
        begin errors++; $display("FAIL store_rsp_valid[%0d]: got %b want 1", k, rsp_valid); end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err})
          begin errors++; $display("FAIL store_rsp[%0d]: got rdata=%h err=%b want rdata=%h err=%b",
                                   k, rsp_rdata, rsp_err, e.rdata, e.err); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_error();
    logic        t_we [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  t_op [8] = '{3'b010, 3'b011, 3'b001, 3'b110, 3'b111, 3'b010, 3'b011, 3'b101};
    logic [31:0] t_ad [8] = '{32'h4002, 32'h4000, 32'h4001, 32'h4000, 32'h4000, 32'h4001, 32'h4000, 32'h4003};
    exp_t        e;
    for (int k = 0; k < 8; k++) begin
      push_exp(32'h0, 1'b1);
      issue(t_we[k], t_op[k], t_ad[k], 32'hFFFF_FFFF);
      @(negedge clk);
      checks++;
      if ({rsp_valid, mem_req, req_ready} !== 3'b100)
        begin errors++; $display("FAIL err_timing[%0d]: got rsp_v/mem_req/ready=%b want 100", k, {rsp_valid, mem_req, req_ready}); end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({rsp_rdata, rsp_err} !== {e.rdata, e.err})
          begin errors++; $display("FAIL err_rsp[%0d]: got rdata=%h err=%b want rdata=%h err=%b",
                                   k, rsp_rdata, rsp_err, e.rdata, e.err); end
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, mem_req, req_ready} !== 3'b001)
        begin errors++; $display("FAIL err_recover[%0d]: got rsp_v/mem_req/ready=%b want 001", k, {rsp_valid, mem_req, req_ready}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op [3] = '{3'b100, 3'b101, 3'b001};
    logic [31:0] ad [3] = '{32'h7000, 32'h7002, 32'h7000};
    logic [31:0] ex [3] = '{32'h0000_00D4, 32'h0000_A1B2, 32'hFFFF_C3D4};
    int   idx = 0, nrsp = 0, cyc = 0, last_hs = -1;
    logic hs;
    exp_t e;
    @(posedge clk); #1;
    mem_rdata = 32'hA1B2_C3D4;
    req_valid = 1'b1; req_we = 1'b0; req_memop = op[0]; req_addr = ad[0]; req_wdata = '0;
    while (cyc < 20 && (idx < 3 || nrsp < 3)) begin
      @(negedge clk);
      hs = req_valid && req_ready;
      mem_ack = mem_req;
      if (rsp_valid) begin
        nrsp++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL b2b_rsp: got unexpected response rdata=%h want none", rsp_rdata);
        end else begin
          e = sb_q.pop_front();
          if ({rsp_rdata, rsp_err} !== {e.rdata, e.err})
            begin errors++; $display("FAIL b2b_rsp[%0d]: got rdata=%h err=%b want rdata=%h err=%b",
                                     nrsp, rsp_rdata, rsp_err, e.rdata, e.err); end
        end
      end
      @(posedge clk); #1;
      if (hs) begin
        push_exp(ex[idx], 1'b0);
        if (last_hs >= 0) begin
          checks++;
          if (cyc - last_hs != 3)
            begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want 3", idx, cyc - last_hs); end
        end
        last_hs = cyc;
        idx++;
        if (idx < 3) begin req_memop = op[idx]; req_addr = ad[idx]; end
        else req_valid = 1'b0;
      end
      cyc++;
    end
    req_valid = 1'b0; mem_ack = 1'b0;
    checks++;
    if (idx != 3 || nrsp != 3)
      begin errors++; $display("FAIL b2b_count: got %0d accepted %0d responses want 3 and 3", idx, nrsp); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    issue(1'b0, 3'b010, 32'h5000, 32'h0);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1)
      begin errors++; $display("FAIL rstmid_bus: got mem_req=%b want 1", mem_req); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, req_ready, rsp_valid} !== 3'b010)
      begin errors++; $display("FAIL rstmid_drop: got mem_req/ready/rsp_v=%b want 010", {mem_req, req_ready, rsp_valid}); end
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL rstmid_stale_ack: got %0d responses ready=%b want 0 responses ready=1", seen, req_ready); end
  endtask

  task automatic test_timeout();
    int   hi = 0;
    int   seen = 0;
    exp_t e;
`ifdef LSU_TIMEOUT_EN
    push_exp(32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h6000, 32'h0);
    repeat (4) begin
      @(negedge clk);
      if (mem_req === 1'b1 && rsp_valid === 1'b0) hi++;
    end
    checks++;
    if (hi != 4)
      begin errors++; $display("FAIL tmo_hold: got %0d bus cycles want 4", hi); end
    @(negedge clk);
    checks++;
    if ({mem_req, rsp_valid} !== 2'b01)
      begin errors++; $display("FAIL tmo_abort: got mem_req/rsp_v=%b want 01", {mem_req, rsp_valid}); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err} !== {e.rdata, e.err})
        begin errors++; $display("FAIL tmo_rsp: got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    end
    // Ack arriving in the limit cycle completes normally.
    push_exp(32'h1357_2468, 1'b0);
    issue(1'b0, 3'b010, 32'h6004, 32'h0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1357_2468;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1)
      begin errors++; $display("FAIL tmo_ack_wins_valid: got %b want 1", rsp_valid); end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err} !== {e.rdata, e.err})
        begin errors++; $display("FAIL tmo_ack_wins: got rdata=%h err=%b want rdata=%h err=%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    end
    @(negedge clk);
`else
    issue(1'b0, 3'b010, 32'h6000, 32'h0);
    repeat (300) begin
      @(negedge clk);
      if (mem_req === 1'b1) hi++;
      if (rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (hi != 300 || seen != 0)
      begin errors++; $display("FAIL no_timeout: got %0d req cycles %0d responses want 300 and 0", hi, seen); end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, req_ready} !== 2'b01)
      begin errors++; $display("FAIL no_timeout_reset: got mem_req/ready=%b want 01", {mem_req, req_ready}); end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    checks++;
    if (sb_q.size() != 0)
      begin errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit on the memory side of the decoder's MemWr/MemOp outputs: accepts one decoded memory operation at a time and issues a single word-aligned access on the data-memory bus.
- Generates byte-lane write masks and replicated write data for stores.
- Extracts and sign/zero-extends load data, then returns a one-cycle response to the writeback stage.
- Sits between execute (ALU address result) and writeback (MemtoReg mux).

Parameters:
- XLEN, 32, data and address width; only 32 is supported.
- TIMEOUT_CYCLES, 255, bus-wait limit used only when the optional feature is compiled in; range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  operation request from execute
- req_ready  out  1  LSU can accept a request this cycle
- req_we  in  1  1 = store (decoder MemWr), 0 = load
- req_memop  in  3  000 B signed, 001 H signed, 010 W, 100 BU, 101 HU; other codes illegal
- req_addr  in  XLEN  byte address from ALU
- req_wdata  in  XLEN  store data (rs2)
- rsp_valid  out  1  single-cycle response pulse
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal memop, or timeout; qualified by rsp_valid
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  bus write enable
- mem_addr  out  XLEN  word address, {req_addr[31:2],2'b00}
- mem_wdata  out  XLEN  lane-replicated store data
- mem_wmask  out  4  byte-lane write mask; 0 for loads
- mem_ack  in  1  bus completion; mem_rdata valid in the same cycle
- mem_rdata  in  XLEN  read word

Behaviour:
- Reset: synchronous, active-high on clk.
  - State returns to IDLE.
  - req_ready is 1 after reset; all other outputs are 0.
  - Reset mid-access drops mem_req at the next edge and discards any later mem_ack.
- FSM states: IDLE, BUS, RESP.
- req_ready = (state == IDLE). A handshake occurs when req_valid && req_ready.
- Handshake in IDLE: address, memop, we and wdata are registered.
  - If the request is illegal or misaligned, the FSM goes to RESP with err = 1 and no bus access.
  - Otherwise the FSM goes to BUS.
- Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
- Illegal memop: 011, 110, 111. This applies to both loads and stores. For stores, memop bits [2] are ignored for legality only if the code is 100 or 101, which are treated as B or H.
- BUS state:
  - mem_req = 1 with mem_we, mem_addr, mem_wdata and mem_wmask held stable.
  - On mem_ack the FSM latches the result and goes to RESP.
  - mem_ack seen outside BUS is ignored.
- RESP state: rsp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- Latency: handshake at cycle T gives mem_req from T+1. mem_ack at cycle A gives rsp_valid at A+1. A zero-wait bus gives rsp_valid at T+2. An error gives rsp_valid at T+1.
- Store byte: wdata = {4{b}}, wmask = 4'b0001 << addr[1:0].
- Store half: wdata = {2{h}}, wmask = addr[1] ? 4'b1100 : 4'b0011.
- Store word: wdata passed through, wmask = 4'b1111.
- Loads: select byte mem_rdata[8*addr[1:0] +: 8] or half mem_rdata[16*addr[1] +: 16].
  - Sign-extend when memop[2] = 0; zero-extend when memop[2] = 1.
  - Word loads pass through.
- Stores and error responses return rsp_rdata = 0.
- Back-to-back: a new request can be accepted in the IDLE cycle after RESP. Throughput is at most one operation per 3 cycles.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears when BUS is entered and increments each BUS cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES without ack, the FSM drops mem_req, goes to RESP with rsp_err = 1 and rsp_rdata = 0.
  - mem_ack in the same cycle as the limit wins: normal completion.
- Undefined: no counter; BUS waits indefinitely for mem_ack.

Test Plan:
- lb, addr 0x1003, mem_rdata 0x80FF_1234, ack after 0 wait -> mem_addr 0x1000, wmask 0, rsp_rdata 0xFFFF_FF80, rsp_err 0, rsp_valid 2 cycles after the handshake.
- lhu, addr 0x2002, mem_rdata 0x8001_7FFF -> rsp_rdata 0x0000_8001; lh at the same address -> 0xFFFF_8001.
- sb, addr 0x3001, wdata 0x1234_56AB -> mem_we 1, mem_wdata 0xABAB_ABAB, wmask 0010. sh, addr 0x3002, wdata 0xCAFE -> wdata 0xCAFE_CAFE, wmask 1100. Both return rsp_rdata 0.
- lw, addr 0x4002 (misaligned) and memop 011 -> no mem_req, rsp_valid 1 cycle after the handshake, rsp_err 1. req_ready low for exactly 1 cycle.
- lw with ack delayed 5 cycles, rst asserted in the 3rd BUS cycle -> mem_req 0 and req_ready 1 the next cycle; the later ack produces no rsp_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, ack never asserted -> mem_req drops after 4 BUS cycles, rsp_err 1. Without the macro, mem_req is still high after 300 cycles.
